uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_if.sv | 41 ++++
 rtl/uart_sync_2ff.sv | 36 +++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter:
//   - default frame geometry (data bits, oversample ticks per bit)
//   - receiver FSM state enumeration
//   - small helpers for the oversample counter compare points
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_DATA_BITS       = 8;
  localparam int DEFAULT_OVERSAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Tick count at which the centre of the start bit is reached, counted
  // from the tick on which the falling edge was first seen.
  function automatic int mid_bit_tick(input int oversample_rate);
    return oversample_rate / 2 - 1;
  endfunction

  // Tick count marking one full bit period.
  function automatic int full_bit_tick(input int oversample_rate);
    return oversample_rate - 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Consumer-side bus of the UART receiver.
//   o_data      : received word, valid while o_valid is high
//   o_valid     : word available, held until accepted
//   i_ready     : consumer accepts o_data when o_valid && i_ready
//   o_frame_err : one-cycle pulse, stop bit sampled low
//   o_overrun   : one-cycle pulse, completed word dropped (o_valid still set)
// Modports:
//   master : the receiver (drives data/valid/flags, reads ready)
//   slave  : the consumer (reads data/valid/flags, drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int P_DATA_BITS = DEFAULT_DATA_BITS
);

  logic [P_DATA_BITS-1:0] o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_frame_err;
  logic                   o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );

endinterface

// File: rtl/uart_sync_2ff.sv
// ---------------------------------------------------------------------------
// uart_sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   i_sys_clk   : destination clock
//   i_sys_rst_n : asynchronous active-low reset, loads P_RESET_VAL
//   i_d         : asynchronous input
//   o_q         : synchronized output (two clock cycles of latency)
// ---------------------------------------------------------------------------
module uart_sync_2ff #(
  parameter logic P_RESET_VAL = 1'b1
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to the idle level of the line so no false start is seen when
  // reset is released.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_meta <= P_RESET_VAL;
      r_sync <= P_RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: P_DATA_BITS data bits, LSB first, no parity,
// one stop bit. The line is synchronized, the start bit is validated at its
// centre, and every following bit is sampled once per P_OVERSAMPLE_RATE
// ticks. Completed words are offered on a valid/ready bus.
// Ports:
//   i_sys_clk         : system clock, rising edge
//   i_sys_rst_n       : asynchronous active-low reset
//   i_oversample_tick : one-cycle strobe at P_OVERSAMPLE_RATE x baud
//   i_rx              : asynchronous serial line, idle high
//   o_busy            : high whenever the FSM is not in IDLE
//   rx_bus            : uart_rx_if.master (o_data/o_valid/i_ready,
//                       o_frame_err, o_overrun)
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_DATA_BITS       = DEFAULT_DATA_BITS,
  parameter int P_OVERSAMPLE_RATE = DEFAULT_OVERSAMPLE_RATE
) (
  input  logic      i_sys_clk,
  input  logic      i_sys_rst_n,
  input  logic      i_oversample_tick,
  input  logic      i_rx,
  output logic      o_busy,
  uart_rx_if.master rx_bus
);

  localparam int C_TICK_W = $clog2(P_OVERSAMPLE_RATE);
  localparam int C_BIT_W  = $clog2(P_DATA_BITS + 1);

  localparam logic [C_TICK_W-1:0] C_TICK_MID =
    C_TICK_W'(mid_bit_tick(P_OVERSAMPLE_RATE));
  localparam logic [C_TICK_W-1:0] C_TICK_END =
    C_TICK_W'(full_bit_tick(P_OVERSAMPLE_RATE));
  localparam logic [C_BIT_W-1:0]  C_BIT_LAST = C_BIT_W'(P_DATA_BITS - 1);

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  logic w_rx_sync;

  uart_sync_2ff #(
    .P_RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .i_d         (i_rx),
    .o_q         (w_rx_sync)
  );

  // -------------------------------------------------------------------------
  // Receive FSM
  // -------------------------------------------------------------------------
  uart_state_e            r_state;
  uart_state_e            w_state_next;
  logic [C_TICK_W-1:0]    r_tick_cnt;
  logic [C_TICK_W-1:0]    w_tick_cnt_next;
  logic [C_BIT_W-1:0]     r_bit_cnt;
  logic [C_BIT_W-1:0]     w_bit_cnt_next;
  logic [P_DATA_BITS-1:0] r_shift;
  logic [P_DATA_BITS-1:0] w_shift_next;
  logic                   w_frame_done;
  logic                   w_frame_bad;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_frame_done    = 1'b0;
    w_frame_bad     = 1'b0;

    // Nothing moves between ticks, so a stalled baud generator freezes the
    // receiver exactly where it is.
    if (i_oversample_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_sync) begin
            w_state_next    = ST_START;
            w_tick_cnt_next = '0;
          end
        end

        ST_START: begin
          if (r_tick_cnt == C_TICK_MID) begin
            w_tick_cnt_next = '0;
            w_bit_cnt_next  = '0;
            // A line that is high again at mid start bit was a glitch.
            w_state_next    = w_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_tick_cnt == C_TICK_END) begin
            w_tick_cnt_next = '0;
            // LSB arrives first: shift in at the top so that after the last
            // bit the first one has reached bit 0.
            w_shift_next    = {w_rx_sync, r_shift[P_DATA_BITS-1:1]};
            if (r_bit_cnt == C_BIT_LAST) begin
              w_bit_cnt_next = '0;
              w_state_next   = ST_STOP;
            end else begin
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (r_tick_cnt == C_TICK_END) begin
            w_tick_cnt_next = '0;
            if (w_rx_sync) begin
              w_frame_done = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_frame_bad  = 1'b1;
              w_state_next = ST_BREAK;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end

        ST_BREAK: begin
          // A held-low line must return high before a new start is accepted,
          // otherwise a break would be decoded as a stream of 0x00 frames.
          if (w_rx_sync) begin
            w_state_next = ST_IDLE;
          end
        end

        default: begin
          w_state_next    = ST_IDLE;
          w_tick_cnt_next = '0;
          w_bit_cnt_next  = '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);

  // -------------------------------------------------------------------------
  // Output holding register and status pulses
  // -------------------------------------------------------------------------
  logic [P_DATA_BITS-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_accept;
  logic                   w_load;

  assign w_accept = r_valid & rx_bus.i_ready;
  // A word handed over in the same cycle frees the register for the new one.
  assign w_load   = w_frame_done & (~r_valid | rx_bus.i_ready);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      // The held word wins: the newly completed one is dropped.
      r_overrun   <= w_frame_done & r_valid & ~rx_bus.i_ready;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_bus.o_data      = r_data;
  assign rx_bus.o_valid     = r_valid;
  assign rx_bus.o_frame_err = r_frame_err;
  assign rx_bus.o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are built from the byte value and
// pushed to an expected queue; a monitor pops and compares on each accepted
// word and accounts for every status pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int OS = 16;
  // Ticks from start detection to stop-bit sample: half a bit, then DW data
  // bits and the stop bit, one full bit each.
  localparam int STOP_TICK = OS / 2 + OS * (DW + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic rx    = 1'b1;
  logic busy;

  uart_rx_if #(.P_DATA_BITS(DW)) bus ();

  uart_rx #(
    .P_DATA_BITS       (DW),
    .P_OVERSAMPLE_RATE (OS)
  ) dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_oversample_tick (tick),
    .i_rx              (rx),
    .o_busy            (busy),
    .rx_bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int valid_cycles = 0;

  // Tick generator: fractional divider, tick_num/tick_den ticks per clock.
  int tick_num = 1;
  int tick_den = 4;
  int tick_acc = 0;
  bit tick_en  = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_acc += tick_num;
        if (tick_acc >= tick_den) begin
          tick_acc -= tick_den;
          tick = 1'b1;
        end else begin
          tick = 1'b0;
        end
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Line as seen two clocks later, used only to find the start-detect tick.
  logic rx_d1 = 1'b1;
  logic rx_d2 = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx;
      rx_d2 <= rx_d1;
    end
  end

  // ------------------------------------------------------------------ monitor
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] prev_data = '0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid) valid_cycles++;
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_byte: got %02h, required no word", bus.o_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.o_data !== mon_exp) begin
            errors++;
            $display("FAIL rx_byte: got %02h, required %02h", bus.o_data, mon_exp);
          end else begin
            $display("rx byte %02h accepted at %0t", bus.o_data, $time);
          end
        end
      end
      if (bus.o_valid && prev_valid && !prev_hs) begin
        checks++;
        if (bus.o_data !== prev_data) begin
          errors++;
          $display("FAIL data_stable: got %02h, required %02h", bus.o_data, prev_data);
        end
      end
      if (bus.o_frame_err) begin
        checks++;
        if (exp_ferr == 0 || prev_ferr) begin
          errors++;
          $display("FAIL frame_err: got pulse, required none");
        end else begin
          exp_ferr--;
          $display("frame_err pulse at %0t", $time);
        end
      end
      if (bus.o_overrun) begin
        checks++;
        if (exp_ovr == 0 || prev_ovr) begin
          errors++;
          $display("FAIL overrun: got pulse, required none");
        end else begin
          exp_ovr--;
          $display("overrun pulse at %0t", $time);
        end
      end
      prev_data  = bus.o_data;
      prev_valid = bus.o_valid;
      prev_hs    = bus.o_valid && bus.i_ready;
      prev_ferr  = bus.o_frame_err;
      prev_ovr   = bus.o_overrun;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_ferr  = 1'b0;
      prev_ovr   = 1'b0;
    end
  end

  // ------------------------------------------------------------------ helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Start bit, data LSB first, stop bit; each bit edge placed at the nearest
  // clock to its ideal position so fractional bit periods do not drift.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit,
                            input real bit_clks, input int nbits = DW + 2);
    int cyc;
    logic [DW+1:0] frame;
    cyc   = 0;
    frame = {stop_bit, d, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      rx = frame[k];
      while (cyc < $rtoi((k + 1) * bit_clks + 0.5)) begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      step();
      n++;
    end
    @(negedge clk);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic drain_check(input string name);
    wait_cycles(8);
    @(negedge clk);
    check({name, "_pending_words"}, exp_q.size(), 0);
    check({name, "_pending_ferr"}, exp_ferr, 0);
    check({name, "_pending_ovr"}, exp_ovr, 0);
    step();
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
    check({name, "_data"}, {24'd0, bus.o_data}, 32'd0);
    check({name, "_frame_err"}, {31'd0, bus.o_frame_err}, 32'd0);
    check({name, "_overrun"}, {31'd0, bus.o_overrun}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Raise i_ready for exactly the cycle whose tick samples the stop bit.
  task automatic ready_at_stop_sample();
    int cnt;
    int guard;
    cnt   = -1;
    guard = 0;
    while (guard < 20000) begin
      @(posedge clk);
      #2;
      guard++;
      if (tick) begin
        if (cnt < 0) begin
          if (!rx_d2) cnt = 0;
        end else begin
          cnt++;
          if (cnt == STOP_TICK) begin
            bus.i_ready = 1'b1;
            @(posedge clk);
            #2;
            bus.i_ready = 1'b0;
            return;
          end
        end
      end
    end
    checks++;
    errors++;
    $display("FAIL ready_pulse_timeout: got no stop tick, required one within 20000 cycles");
  endtask

  // -------------------------------------------------------------------- main
  initial begin
    real fast_bit;
    real nominal_bit;
    logic [DW-1:0] rnd;
    logic [DW-1:0] slow_bytes[3];
    real factors[2];

    bus.i_ready = 1'b1;
    rx          = 1'b1;
    rst_n       = 1'b0;
    fast_bit    = real'(OS * tick_den) / real'(tick_num);

    repeat (3) step();
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_cycles(5);

    // Single clean frame with the consumer always ready.
    valid_cycles = 0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, fast_bit);
    wait_idle("f55", 2000);
    wait_cycles(20);
    @(negedge clk);
    check("f55_valid_cycles", valid_cycles, 1);
    step();
    drain_check("f55");

    // Stop bit low, then the line held low for 40 bit times.
    valid_cycles = 0;
    exp_ferr++;
    send_frame(8'hA3, 1'b0, fast_bit);
    rx = 1'b0;
    wait_cycles(40 * $rtoi(fast_bit));
    @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_ferr_seen", exp_ferr, 0);
    step();
    rx = 1'b1;
    wait_cycles(2 * $rtoi(fast_bit));
    @(negedge clk);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    check("break_valid_cycles", valid_cycles, 0);
    step();
    drain_check("break");

    // Five-tick low glitch on an idle line.
    valid_cycles = 0;
    rx = 1'b0;
    wait_cycles(5 * tick_den);
    rx = 1'b1;
    wait_cycles(3 * $rtoi(fast_bit));
    @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid_cycles", valid_cycles, 0);
    step();
    drain_check("glitch");

    // No ticks: a low line and a toggling ready must change nothing.
    tick_en = 1'b0;
    wait_cycles(2);
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.i_ready = i[0];
      step();
    end
    rx = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check("noticks_busy", {31'd0, busy}, 32'd0);
    check("noticks_valid_cycles", valid_cycles, 0);
    step();
    bus.i_ready = 1'b1;
    tick_en     = 1'b1;
    wait_cycles(4);

    // Two frames, consumer stalled: first held, second dropped.
    bus.i_ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_ovr++;
    send_frame(8'h12, 1'b1, fast_bit);
    wait_cycles($rtoi(fast_bit));
    send_frame(8'h34, 1'b1, fast_bit);
    wait_cycles(16);
    @(negedge clk);
    check("ovr_held_data", {24'd0, bus.o_data}, 32'h12);
    check("ovr_held_valid", {31'd0, bus.o_valid}, 32'd1);
    check("ovr_pulse_seen", exp_ovr, 0);
    step();
    bus.i_ready = 1'b1;
    drain_check("ovr");

    // Same pair, with ready raised in the completion cycle of the second.
    bus.i_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, fast_bit);
    wait_cycles($rtoi(fast_bit));
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h34, 1'b1, fast_bit);
      ready_at_stop_sample();
    join
    wait_cycles(8);
    @(negedge clk);
    check("swap_data", {24'd0, bus.o_data}, 32'h34);
    check("swap_valid", {31'd0, bus.o_valid}, 32'd1);
    check("swap_queue", exp_q.size(), 1);
    step();
    bus.i_ready = 1'b1;
    drain_check("swap");

    // Reset in the middle of data bit 4 of 0xF0, then a clean 0x0F.
    send_frame(8'hF0, 1'b1, fast_bit, 5);
    rx = 1'b1;
    wait_cycles($rtoi(fast_bit) / 2);
    rst_n = 1'b0;
    wait_cycles(3);
    check_reset_state("midreset");
    step();
    rst_n = 1'b1;
    wait_cycles(2 * $rtoi(fast_bit));
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, fast_bit);
    wait_idle("after_reset", 2000);
    drain_check("after_reset");

    // Random words with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      rnd = DW'($urandom);
      exp_q.push_back(rnd);
      send_frame(rnd, 1'b1, fast_bit);
      wait_cycles($urandom_range(0, 3) * $rtoi(fast_bit));
    end
    wait_idle("random", 2000);
    drain_check("random");

    // 115200 baud ticks from a 100 MHz clock, transmitter off by +/-3 %.
    tick_num    = 1843200;
    tick_den    = 100000000;
    tick_acc    = 0;
    nominal_bit = 100.0e6 / 115200.0;
    slow_bytes[0] = 8'h00;
    slow_bytes[1] = 8'hFF;
    slow_bytes[2] = 8'h81;
    factors[0] = 1.03;
    factors[1] = 0.97;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) begin
        exp_q.push_back(slow_bytes[b]);
        send_frame(slow_bytes[b], 1'b1, nominal_bit / factors[f]);
        wait_cycles($rtoi(nominal_bit));
      end
    end
    wait_idle("baud", 4000);
    drain_check("baud");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running, required finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
